// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and
// the baud divider helper used by both receiver and transmitter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic int baud_divider(
    input int clk_hz,
    input int baud,
    input int os
  );
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator, one clk pulse per
// DIVIDER clocks; shared between UART receiver and transmitter.
module uart_baud_tick import uart_pkg::*; #(
  parameter int CLOCK_FREQ = 27000000,
  parameter int BAUD_RATE  = 1000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIVIDER =
    baud_divider(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

  if (DIVIDER < 1) begin : g_bad_div
    $error("uart_baud_tick: clock too slow for baud * oversample");
  end

  logic [CW-1:0] cnt;

  // divider counter wraps at DIVIDER-1
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output and error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_rx_param import uart_pkg::*; #(
  parameter int CLOCK_FREQ  = 27000000,
  parameter int BAUD_RATE   = 1000000,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  localparam int TCW = $clog2(OVERSAMPLE + MAJ);
  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TCW-1:0] START_AT =
    TCW'(OVERSAMPLE / 2 - 1 + MAJ);
  localparam logic [TCW-1:0] BIT_AT = TCW'(OVERSAMPLE - 1 + MAJ);
  localparam logic [TCW-1:0] CLR    = TCW'(MAJ);
  localparam logic [BCW-1:0] DLAST  = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] SLAST  = BCW'(STOP_BITS - 1);

  uart_state_t state, state_n;

  logic                 tick;
  logic                 rx_q1, rx_s, rx_d;
  logic                 fall, decide, bit_val, par_calc;
  logic [TCW-1:0]       tick_cnt, dec_at;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg, fr_data;
  logic                 perr, ferr, done, fr_perr, fr_ferr;

  uart_baud_tick #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // two-flop synchroniser plus one delay flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
      rx_d  <= rx_s;
    end
  end

  assign fall   = rx_d & ~rx_s;
  assign busy   = (state != IDLE);
  assign dec_at = (state == START) ? START_AT : BIT_AT;
  assign decide = tick && busy && (tick_cnt == dec_at);

`ifdef UART_RX_MAJORITY_EN
  logic v0, v1;

  // capture the two samples preceding the decision tick
  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else if (tick) begin
      if (tick_cnt == dec_at - TCW'(2)) v0 <= rx_s;
      if (tick_cnt == dec_at - TCW'(1)) v1 <= rx_s;
    end
  end

  assign bit_val = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign par_calc = (^shreg) ^ bit_val;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (fall) state_n = START;
      START:  if (decide) state_n = bit_val ? IDLE : DATA;
      DATA:
        if (decide && bit_cnt == DLAST)
          state_n = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
      PARITY: if (decide) state_n = STOP;
      STOP:   if (decide && bit_cnt == SLAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // bit timing, shift register and per-frame status
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      done     <= 1'b0;
      fr_data  <= '0;
      fr_perr  <= 1'b0;
      fr_ferr  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (fall) begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          perr     <= 1'b0;
          ferr     <= 1'b0;
        end
      end else if (tick) begin
        tick_cnt <= decide ? CLR : tick_cnt + TCW'(1);
        if (decide) begin
          unique case (1'b1)
            state == DATA: begin
              shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
              bit_cnt <= (bit_cnt == DLAST) ? '0 : bit_cnt + BCW'(1);
            end
            state == PARITY:
              perr <= (PARITY_MODE == PARITY_ODD) ? ~par_calc : par_calc;
            state == STOP: begin
              ferr    <= ferr | ~bit_val;
              bit_cnt <= bit_cnt + BCW'(1);
              if (bit_cnt == SLAST) begin
                done    <= 1'b1;
                fr_data <= shreg;
                fr_perr <= perr;
                fr_ferr <= ferr | ~bit_val;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // output holding register and valid/ready handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out    <= '0;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (done) begin
      if (!valid || ready) begin
        data_out   <= fr_data;
        parity_err <= fr_perr;
        frame_err  <= fr_ferr;
        valid      <= 1'b1;
        if (valid) overrun_err <= 1'b0;
      end else begin
        overrun_err <= 1'b1;
      end
    end else if (valid && ready) begin
      valid       <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised self-checking bench for uart_rx_param: 8E1, 8O1 and
// 7N2 instances driven bit-serially and compared to a frame model.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx_v, rdy, vld, pe, fe, ov, bsy;
  logic [7:0] d0, d1;
  logic [6:0] d2;

  int n_chk = 0;
  int n_fail = 0;

  int nd[3] = '{8, 8, 7};
  int pm[3] = '{1, 2, 0};
  int ns[3] = '{1, 1, 2};

  logic [10:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  uart_rx_param #(.CLOCK_FREQ(16000000), .BAUD_RATE(1000000),
    .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .rst(rst), .rx(rx_v[0]), .data_out(d0),
    .valid(vld[0]), .ready(rdy[0]), .parity_err(pe[0]),
    .frame_err(fe[0]), .overrun_err(ov[0]), .busy(bsy[0])
  );

  uart_rx_param #(.CLOCK_FREQ(16000000), .BAUD_RATE(1000000),
    .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)
  ) dut1 (
    .clk(clk), .rst(rst), .rx(rx_v[1]), .data_out(d1),
    .valid(vld[1]), .ready(rdy[1]), .parity_err(pe[1]),
    .frame_err(fe[1]), .overrun_err(ov[1]), .busy(bsy[1])
  );

  uart_rx_param #(.CLOCK_FREQ(16000000), .BAUD_RATE(1000000),
    .OVERSAMPLE(16), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)
  ) dut2 (
    .clk(clk), .rst(rst), .rx(rx_v[2]), .data_out(d2),
    .valid(vld[2]), .ready(rdy[2]), .parity_err(pe[2]),
    .frame_err(fe[2]), .overrun_err(ov[2]), .busy(bsy[2])
  );

  always @(negedge clk) begin
    if (vld[0] && rdy[0]) q0.push_back({fe[0], pe[0], 1'b0, d0});
    if (vld[1] && rdy[1]) q1.push_back({fe[1], pe[1], 1'b0, d1});
    if (vld[2] && rdy[2]) q2.push_back({fe[2], pe[2], 2'b0, d2});
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mk(input int ln, input logic [8:0] d, input logic pb,
                    input logic s1, input logic s2,
                    output logic [15:0] fb, output int n);
    fb = '1;
    fb[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nd[ln]; i++) begin
      fb[n] = d[i];
      n++;
    end
    if (pm[ln] != 0) begin
      fb[n] = pb;
      n++;
    end
    fb[n] = s1;
    n++;
    if (ns[ln] == 2) begin
      fb[n] = s2;
      n++;
    end
  endtask

  task automatic send(input int ln, input logic [15:0] fb,
                      input int n, input int gl);
    for (int b = 0; b < n; b++)
      for (int c = 0; c < 16; c++) begin
        rx_v[ln] = fb[b] ^ ((b == gl) && (c == 8));
        steps(1);
      end
    rx_v[ln] = 1'b1;
  endtask

  task automatic pop(input int ln, output logic [10:0] e,
                     output int sz);
    e = '0;
    if (ln == 0) begin
      sz = q0.size();
      if (sz > 0) e = q0.pop_front();
    end else if (ln == 1) begin
      sz = q1.size();
      if (sz > 0) e = q1.pop_front();
    end else begin
      sz = q2.size();
      if (sz > 0) e = q2.pop_front();
    end
  endtask

  function automatic logic [8:0] mask(input int ln, input logic [8:0] d);
    return d & 9'((1 << nd[ln]) - 1);
  endfunction

  function automatic logic good_par(input int ln, input logic [8:0] d);
    return (pm[ln] == 2) ? ~(^mask(ln, d)) : ^mask(ln, d);
  endfunction

  // full frame on one lane, then compare the delivered word to the model
  task automatic frame(input string tag, input int ln,
                       input logic [8:0] d, input logic pb,
                       input logic s1, input logic s2, input int gl);
    logic [15:0] fb;
    int          n, sz;
    logic [10:0] e;
    logic [8:0]  dm;
    logic        ep, ef;
    mk(ln, d, pb, s1, s2, fb, n);
    send(ln, fb, n, gl);
    steps(10);
    dm = mask(ln, d);
    ep = 1'b0;
    if (pm[ln] == 1) ep = (^dm) ^ pb;
    if (pm[ln] == 2) ep = ~((^dm) ^ pb);
    ef = ~s1 | ((ns[ln] == 2) & ~s2);
    pop(ln, e, sz);
    chk({tag, "_cnt"}, sz, 1);
    chk({tag, "_data"}, e[8:0], dm);
    chk({tag, "_perr"}, e[9], ep);
    chk({tag, "_ferr"}, e[10], ef);
    chk({tag, "_ovr"}, ov[ln], 1'b0);
  endtask

  initial begin
    logic [15:0] fb;
    int          n, sz, ln;
    logic [10:0] e;
    logic [8:0]  d;
    logic        pb, s1, s2;

    rst = 1'b1;
    rx_v = '1;
    rdy = '1;
    steps(4);
    chk("rst_data", d0, 8'h00);
    chk("rst_valid", vld[0], 1'b0);
    chk("rst_perr", pe[0], 1'b0);
    chk("rst_ferr", fe[0], 1'b0);
    chk("rst_ovr", ov[0], 1'b0);
    chk("rst_busy", bsy, 3'b000);
    rst = 1'b0;
    steps(4);

    rx_v[0] = 1'b0;
    steps(4);
    rx_v[0] = 1'b1;
    steps(8);
    chk("glitch_busy", bsy[0], 1'b0);
    steps(20);
    chk("glitch_nvalid", q0.size(), 0);
    chk("glitch_flags", {pe[0], fe[0], ov[0]}, 3'b000);

    frame("a5", 0, 9'h0A5, 1'b0, 1'b1, 1'b1, -1);
    chk("a5_vlow", vld[0], 1'b0);
    frame("par_even", 0, 9'h001, 1'b0, 1'b1, 1'b1, -1);
    frame("par_odd", 1, 9'h001, 1'b0, 1'b1, 1'b1, -1);

    rdy[0] = 1'b0;
    mk(0, 9'h011, 1'b0, 1'b1, 1'b1, fb, n);
    send(0, fb, n, -1);
    steps(10);
    mk(0, 9'h022, 1'b0, 1'b1, 1'b1, fb, n);
    send(0, fb, n, -1);
    steps(10);
    chk("ovr_data", d0, 8'h11);
    chk("ovr_valid", vld[0], 1'b1);
    chk("ovr_flag", ov[0], 1'b1);
    rdy[0] = 1'b1;
    steps(1);
    chk("ovr_hs_valid", vld[0], 1'b0);
    chk("ovr_hs_flag", ov[0], 1'b0);
    pop(0, e, sz);
    chk("ovr_hs_word", {sz[3:0], e[7:0]}, 12'h111);

    frame("7n2_stop2", 2, 9'h055, 1'b0, 1'b1, 1'b0, -1);

    mk(0, 9'h03C, 1'b0, 1'b1, 1'b1, fb, n);
    send(0, fb, 4, -1);
    rx_v[0] = 1'b0;
    rst = 1'b1;
    steps(3);
    rx_v[0] = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(30);
    chk("rst_abort_busy", bsy[0], 1'b0);
    chk("rst_abort_none", q0.size(), 0);
`ifdef UART_RX_MAJORITY_EN
    frame("after_rst_maj", 0, 9'h07E, 1'b0, 1'b1, 1'b1, 4);
`else
    frame("after_rst", 0, 9'h07E, 1'b0, 1'b1, 1'b1, -1);
`endif

    for (int i = 0; i < 24; i++) begin
      ln = $urandom_range(0, 2);
      d = 9'($urandom);
      pb = good_par(ln, d) ^ ($urandom_range(0, 3) == 0);
      s1 = ($urandom_range(0, 5) != 0);
      s2 = ($urandom_range(0, 5) != 0);
      frame($sformatf("rnd%0d_l%0d", i, ln), ln, d, pb, s1, s2, -1);
      steps(4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
